// File: rtl/fp_pkg.sv
// Shared fields, stage payloads and constants for the pipelined FP subtractor.
// Widths follow EXPONENT/MANTISSA from config_sys.vh; the 8/23 fallback applies when that header is absent.
`ifndef EXPONENT
`define EXPONENT 8
`endif
`ifndef MANTISSA
`define MANTISSA 23
`endif

package fp_pkg;
  localparam int unsigned FP_EXP_W = `EXPONENT;
  localparam int unsigned FP_MAN_W = `MANTISSA;
  localparam int unsigned FP_W     = FP_EXP_W + FP_MAN_W + 1;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_INF  = 2'd1,
    EXC_NAN  = 2'd2
  } exc_t;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] ex;
    logic [FP_MAN_W:0]   mx;
    logic [FP_MAN_W:0]   my_al;
    logic                eff_sub;
    exc_t                exc;
  } fp_s1_t;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] ex;
    logic [FP_MAN_W+1:0] sum;
    exc_t                exc;
  } fp_s2_t;

  localparam logic [FP_W-1:0] FP_QNAN    = {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};
  localparam logic [FP_W-1:0] FP_POS_INF = {1'b0, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
endpackage

// File: rtl/fp_sub_pipe_if.sv
// Operand/result handshake bundle for fp_sub_pipe; slave is the subtractor side.
interface fp_sub_pipe_if import fp_pkg::*; #(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   a_operand;
  logic [EXP_W+MAN_W:0]   b_operand;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   result;

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int unsigned W  = 24,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (d_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fp_sub_pipe.sv
// Three-stage a-b subtractor (align, add/sub, normalise) with a whole-pipe stall.
// FP_SUB_EXC_EN adds Inf/NaN handling and overflow-to-Inf; otherwise exponents wrap.
module fp_sub_pipe import fp_pkg::*; #(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input logic          clk,
  input logic          rst,
  fp_sub_pipe_if.slave bus
);
  localparam int unsigned W   = EXP_W + MAN_W + 1;
  localparam int unsigned LZW = $clog2(MAN_W + 2);

  logic             v1_q, v2_q, v3_q, adv;
  fp_s1_t           s1_d, s1_q;
  fp_s2_t           s2_d, s2_q;
  logic [W-1:0]     res_d, result_q;
  logic [LZW-1:0]   lz;

  logic             sa, sb, a_big, sx;
  logic [EXP_W-1:0] ea, eb, ex_raw, ey_raw, ex_eff, ey_eff, d, exp_n;
  logic [MAN_W-1:0] ma, mb, man_x, man_y, norm;
  logic [MAN_W:0]   my;

  assign {sa, ea, ma} = bus.a_operand;
  assign {sb, eb, mb} = bus.b_operand;

  assign adv           = !v3_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.result    = result_q;

  // Stage 1: b's sign is flipped; a denormal is weighted like exponent 1.
  always_comb begin
    s1_d   = '0;
    a_big  = {ea, ma} >= {eb, mb};
    sx     = a_big ? sa : ~sb;
    ex_raw = a_big ? ea : eb;
    ey_raw = a_big ? eb : ea;
    man_x  = a_big ? ma : mb;
    man_y  = a_big ? mb : ma;
    ex_eff = (ex_raw == '0) ? EXP_W'(1) : ex_raw;
    ey_eff = (ey_raw == '0) ? EXP_W'(1) : ey_raw;
    d      = ex_eff - ey_eff;
    my     = {|ey_raw, man_y};
    s1_d.sign    = sx;
    s1_d.ex      = ex_eff;
    s1_d.mx      = {|ex_raw, man_x};
    s1_d.my_al   = (32'(d) >= MAN_W + 1) ? '0 : (my >> d);
    s1_d.eff_sub = (sa == sb);
    s1_d.exc     = EXC_NONE;
`ifdef FP_SUB_EXC_EN
    if (((&ea) && (ma != '0)) || ((&eb) && (mb != '0)) ||
        ((&ea) && (&eb) && (ma == '0) && (mb == '0) && (sa == sb)))
      s1_d.exc = EXC_NAN;
    else if (((&ea) && (ma == '0)) || ((&eb) && (mb == '0)))
      s1_d.exc = EXC_INF;
`endif
  end

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.ex   = s1_q.ex;
    s2_d.exc  = s1_q.exc;
    s2_d.sum  = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my_al})
                             : ({1'b0, s1_q.mx} + {1'b0, s1_q.my_al});
  end

  fp_lzc #(.W(MAN_W + 1), .CW(LZW)) u_lzc (
    .d_i  (s2_q.sum[MAN_W:0]),
    .cnt_o(lz)
  );

  always_comb begin
    res_d = '0;
    norm  = '0;
    exp_n = '0;
    if (s2_q.sum[MAN_W+1]) begin
      exp_n = s2_q.ex + EXP_W'(1);
      res_d = {s2_q.sign, exp_n, s2_q.sum[MAN_W:1]};
`ifdef FP_SUB_EXC_EN
      if (&exp_n) res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`endif
    end else if (s2_q.sum == '0) begin
      res_d = '0;
    end else if (32'(s2_q.ex) > 32'(lz)) begin
      norm  = MAN_W'(s2_q.sum[MAN_W:0] << lz);
      exp_n = s2_q.ex - EXP_W'(lz);
      res_d = {s2_q.sign, exp_n, norm};
    end else begin
      norm  = MAN_W'(s2_q.sum[MAN_W:0] << (s2_q.ex - EXP_W'(1)));
      res_d = {s2_q.sign, {EXP_W{1'b0}}, norm};
    end
    if (s2_q.exc == EXC_NAN)
      res_d = FP_QNAN;
    else if (s2_q.exc == EXC_INF)
      res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      result_q <= '0;
    end else if (adv) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) result_q <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      if (bus.in_valid) s1_q <= s1_d;
      if (v1_q)         s2_q <= s2_d;
    end
  end
endmodule

// File: tb/tb_fp_sub_pipe.sv
// Scoreboard bench for fp_sub_pipe: directed single-precision vectors, stall stream, reset drop.
module tb_fp_sub_pipe;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sub_pipe_if #(.EXP_W(FP_EXP_W), .MAN_W(FP_MAN_W)) bus ();
  fp_sub_pipe #(.EXP_W(FP_EXP_W), .MAN_W(FP_MAN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Result must match the head of the queue every cycle it is valid, stalled or not.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out actual %h required none", bus.result);
        end else begin
          check("result", bus.result, exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_latency(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e);
    int lat;
    @(posedge clk); #1;
    bus.a_operand = a;
    bus.b_operand = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, {31'd0, bus.in_ready}, 32'd1);
    exp_q.push_back(e);
    @(posedge clk);
    lat = 1;
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    repeat (2) @(posedge clk);
  endtask

  logic [31:0] va[8] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                         32'h3FC00000, 32'h40000000, 32'h41200000, 32'h00000000};
  logic [31:0] vb[8] = '{32'h3F800000, 32'h40400000, 32'hBF800000, 32'h3F800000,
                         32'h3F800000, 32'h3F800000, 32'h40A00000, 32'h3F800000};
  logic [31:0] ve[8] = '{32'h40000000, 32'hC0000000, 32'h40000000, 32'h00000000,
                         32'h3F000000, 32'h3F800000, 32'h40A00000, 32'hBF800000};
  logic [3:0]  pat   = 4'b1001;

  initial begin
    int idx, cyc;
    logic acc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_operand = '0;
    bus.b_operand = '0;
    #2;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #2 rst = 1'b0;

    send_latency("sub_3_1", 32'h40400000, 32'h3F800000, 32'h40000000);
    send_latency("sub_1_3", 32'h3F800000, 32'h40400000, 32'hC0000000);
    send_latency("carry", 32'h3F800000, 32'hBF800000, 32'h40000000);
    send_latency("zero", 32'h3F800000, 32'h3F800000, 32'h00000000);
    send_latency("norm1", 32'h3FC00000, 32'h3F800000, 32'h3F000000);
`ifdef FP_SUB_EXC_EN
    send_latency("inf_fin", 32'h7F800000, 32'h3F800000, 32'h7F800000);
    send_latency("inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000);
    send_latency("ovf_inf", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000);
`else
    send_latency("ovf_wrap", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7FFFFFFF);
`endif

    // Back-to-back stream under a 1,0,0,1 out_ready pattern.
    idx = 0;
    cyc = 0;
    acc = 1'b0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      if (acc) idx++;
      acc          = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = pat[cyc % 4];
      cyc++;
      if (idx == 8) break;
      bus.in_valid  = 1'b1;
      bus.a_operand = va[idx];
      bus.b_operand = vb[idx];
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(ve[idx]);
        acc = 1'b1;
      end
    end
    check("stream_issued", 32'(idx), 32'd8);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
      bus.out_ready = pat[cyc % 4];
      cyc++;
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Two pairs in flight, stalled, then dropped by an asynchronous reset.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_operand = 32'h40400000;
    bus.b_operand = 32'h3F800000;
    exp_q.push_back(32'h40000000);
    @(posedge clk); #1;
    bus.a_operand = 32'h3FC00000;
    exp_q.push_back(32'h3F000000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_result", bus.result, 32'd0);
    check("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b0;
    send_latency("post_rst", 32'h40400000, 32'hC0000000, 32'h40A00000);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
